// File: rtl/preg_freelist_pkg.sv
// preg_freelist_pkg: shared sizing constants and pointer/index types for the physical-register free list.
package preg_freelist_pkg;
  localparam int NUM_PREGS = 64;
  localparam int NUM_AREGS = 32;
  localparam int MAX_PREDICT_DEPTH = 4;
  localparam int MAX_PREDICT_DEPTH_BITS = 3;
  localparam int PREG_BITS = $clog2(NUM_PREGS);
  localparam int PTR_BITS = PREG_BITS + 1;
  typedef logic [PREG_BITS-1:0] preg_t;
  typedef logic [PTR_BITS-1:0] ptr_t;
  typedef logic [MAX_PREDICT_DEPTH_BITS-1:0] tag_t;
endpackage

// File: rtl/preg_freelist_ckpt_table.sv
// freelist_ckpt_table: one saved head pointer per speculative branch tag (tags 1..MAX_PREDICT_DEPTH).
module freelist_ckpt_table
  import preg_freelist_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en_i,
  input  logic [MAX_PREDICT_DEPTH_BITS-1:0] wr_tag_i,
  input  logic [PTR_BITS-1:0]               wr_ptr_i,
  input  logic [MAX_PREDICT_DEPTH_BITS-1:0] rd_tag_i,
  output logic [PTR_BITS-1:0]               rd_ptr_o
);
  ptr_t ckpt_q [MAX_PREDICT_DEPTH];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_PREDICT_DEPTH; i++) ckpt_q[i] <= '0;
    end else if (wr_en_i) begin
      for (int i = 0; i < MAX_PREDICT_DEPTH; i++)
        if (wr_tag_i == tag_t'(i + 1)) ckpt_q[i] <= wr_ptr_i;
    end
  end
  always_comb begin
    rd_ptr_o = '0;
    for (int i = 0; i < MAX_PREDICT_DEPTH; i++)
      if (rd_tag_i == tag_t'(i + 1)) rd_ptr_o = ckpt_q[i];
  end
endmodule

// File: rtl/preg_freelist.sv
// preg_freelist: circular FIFO of free physical registers; two allocations and two frees per cycle,
// with head-pointer checkpoints restored on branch shootdown.
module preg_freelist
  import preg_freelist_pkg::*;
(
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enabled,
  input  logic [1:0]                        num_execute,
  output logic [PREG_BITS-1:0]              preg1,
  output logic [PREG_BITS-1:0]              preg2,
  output logic                              stalled,
  output logic [PTR_BITS-1:0]               free_count,
  input  logic [1:0]                        free_valid,
  input  logic [PREG_BITS-1:0]              free_preg1,
  input  logic [PREG_BITS-1:0]              free_preg2,
  input  logic                              checkpoint_en,
  input  logic [MAX_PREDICT_DEPTH_BITS-1:0] checkpoint_tag,
  input  logic                              freelist_branch_shootdown,
  input  logic [MAX_PREDICT_DEPTH_BITS-1:0] freelist_shootdown_branch_tag
);
  preg_t fifo_q [NUM_PREGS];
  ptr_t  head_q, head_d, tail_q, tail_d, ckpt_ptr;
  preg_t head_idx, head_idx1, wr_idx1, wr_idx2;
  logic  alloc;

  freelist_ckpt_table u_ckpt (
    .clk      (clk),
    .rst_n    (reset),
    .wr_en_i  (checkpoint_en),
    .wr_tag_i (checkpoint_tag),
    .wr_ptr_i (head_q),
    .rd_tag_i (freelist_shootdown_branch_tag),
    .rd_ptr_o (ckpt_ptr)
  );

  // Allocation only sees the pre-cycle contents; same-cycle frees never bypass.
  always_comb begin
    free_count = tail_q - head_q;
    head_idx   = head_q[PREG_BITS-1:0];
    head_idx1  = head_idx + preg_t'(1);
    preg1      = fifo_q[head_idx];
    preg2      = fifo_q[head_idx1];
    stalled    = ptr_t'(num_execute) > free_count;
    alloc      = enabled && !stalled && !freelist_branch_shootdown;
    head_d     = freelist_branch_shootdown
               ? (freelist_shootdown_branch_tag != '0 ? ckpt_ptr : head_q)
               : (alloc ? head_q + ptr_t'(num_execute) : head_q);
    wr_idx1    = tail_q[PREG_BITS-1:0];
    wr_idx2    = wr_idx1 + preg_t'(free_valid[0]);
    tail_d     = tail_q + ptr_t'(free_valid[0]) + ptr_t'(free_valid[1]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= ptr_t'(NUM_PREGS - 1);
      for (int i = 0; i < NUM_PREGS; i++) fifo_q[i] <= preg_t'(i + 1);
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      if (free_valid[0]) fifo_q[wr_idx1] <= free_preg1;
      if (free_valid[1]) fifo_q[wr_idx2] <= free_preg2;
    end
  end

  a_ckpt_tag: assert property (@(posedge clk) disable iff (!reset)
    checkpoint_en |-> checkpoint_tag != '0)
    else $fatal(1, "preg_freelist: checkpoint with tag 0");
  a_free_full: assert property (@(posedge clk) disable iff (!reset)
    free_valid != 2'b00 |-> free_count != ptr_t'(NUM_PREGS - 1))
    else $fatal(1, "preg_freelist: free while list is full");
endmodule

// File: doc/preg_freelist.md
# preg_freelist

Physical-register free list feeding `uop_issue_commit`. Each cycle it supplies up to two free physical register indices as `preg1`/`preg2` for the instructions being issued, and takes back up to two indices released by commit. On a branch shootdown it restores the allocation pointer from a per-branch-tag checkpoint, so that registers allocated down a mispredicted path are reclaimed. Storage is a circular FIFO of preg indices, with read (head) and write (tail) pointers that each carry a wrap bit.

## Interface
- NUM_PREGS, 64, physical registers (power of two)
- NUM_AREGS, 32, architectural registers
- MAX_PREDICT_DEPTH, 4, speculative branch levels; tags 1..MAX_PREDICT_DEPTH, tag 0 = non-speculative
- MAX_PREDICT_DEPTH_BITS, 3, tag width

- clk  in  1  clock; all state changes on posedge
- reset  in  1  asynchronous, active-low; asserted at 0
- enabled  in  1  stage advance enable
- num_execute  in  2  allocations requested this cycle (0..2; 3 is illegal)
- preg1  out  $clog2(NUM_PREGS)  entry at head (combinational)
- preg2  out  $clog2(NUM_PREGS)  entry at head+1 (combinational)
- stalled  out  1  num_execute > free_count (combinational)
- free_count  out  $clog2(NUM_PREGS)+1  tail − head
- free_valid  in  2  bit i set = free_preg[i] returned this cycle
- free_preg1, free_preg2  in  $clog2(NUM_PREGS)  released indices
- checkpoint_en  in  1  capture the current head for checkpoint_tag
- checkpoint_tag  in  MAX_PREDICT_DEPTH_BITS  1..MAX_PREDICT_DEPTH
- freelist_branch_shootdown  in  1  restore the head pointer
- freelist_shootdown_branch_tag  in  MAX_PREDICT_DEPTH_BITS  tag to restore

## Operation
- **Reset.** Asynchronous, active-low.
  - FIFO entries 0..NUM_PREGS-2 hold pregs 1..NUM_PREGS-1.
  - head = 0, tail = NUM_PREGS-1 with wrap bit 0, so free_count = NUM_PREGS-1.
  - preg 0 is reserved as the reset mapping of every areg.
  - All checkpoints are cleared to 0; stalled = 0.
- **Allocate.** When `enabled && !stalled && !freelist_branch_shootdown`, head += num_execute.
  - Entries are not erased on allocation.
  - preg1 is consumed when num_execute ≥ 1; preg2 only when num_execute = 2.
- **Free.** Each set `free_valid` bit writes its index at the tail, in order: free_preg1 first, then free_preg2. Tail advances by popcount(free_valid).
  - Frees are never blocked.
  - Freeing when free_count = NUM_PREGS-1 is a fatal assertion.
- **Checkpoint.** On `checkpoint_en`, ckpt[checkpoint_tag-1] ← head value before this cycle's allocation.
  - If checkpoint_tag is 0, a fatal assertion fires.
- **Shootdown.** head ← ckpt[tag-1] (tag 0 restores nothing).
  - Allocation is suppressed in that cycle.
  - Frees in the same cycle still apply.
  - Checkpoints with index ≥ tag-1 become don't-care.
- **Pointer arithmetic.** Pointers are $clog2(NUM_PREGS)+1 bits wide and wrap naturally. free_count = tail − head, using the same width.
- **Free-then-allocate in one cycle.** No bypass: allocation only sees entries that were present at the start of the cycle. stalled is computed from the pre-cycle free_count.

## Timing
- preg1, preg2, stalled and free_count are combinational from the registered pointers.
  - They are valid in the same cycle that num_execute is presented.
  - `uop_issue_commit` latches them at the same edge that this block advances head.
- A freed preg becomes allocatable on the cycle after its free edge.
- After a shootdown, the restored preg1 is visible one cycle after the shootdown edge.
- Reset asserted mid-operation returns all state to the reset values immediately; outputs follow combinationally.
- Boundary cases:
  - free_count = 1 with num_execute = 2: stalled = 1 and head does not move.
  - free_count = 0: preg outputs are don't-care.

## Structure
- Shared package (with `defines.inc`): NUM_PREGS, NUM_AREGS, MAX_PREDICT_DEPTH, MAX_PREDICT_DEPTH_BITS, and a `preg_t` typedef.
- One sub-module: `freelist_ckpt_table`, holding MAX_PREDICT_DEPTH head-pointer registers with one write port and one read port.
- The FIFO array and pointers stay in `preg_freelist`.

## Test plan
- **Reset.** Deassert reset → preg1 = 1, preg2 = 2, free_count = 63, stalled = 0.
- **Drain to empty.** num_execute = 2 for 31 cycles → free_count = 1. Then num_execute = 2 → stalled = 1 and head held. Then num_execute = 1 → preg1 = 63 consumed and free_count = 0.
- **Free and allocate in one cycle.** At free_count = 0, free_valid = 2'b11 with pregs 5 and 9, num_execute = 1 → stalled = 1 that cycle. Next cycle preg1 = 5, preg2 = 9, free_count = 2.
- **Shootdown restore.** checkpoint_en with tag 1 at head = 10. Allocate 6 (head = 16). Shootdown with tag 1 → head = 10, free_count up by 6, preg1 = entry 10 again.
- **Shootdown with simultaneous activity.** Shootdown, num_execute = 2 and free_valid = 2'b01 in the same cycle → no allocation; tail advances by 1.
- **Wrap and mid-operation reset.** Cycle the pointers past NUM_PREGS twice with balanced alloc/free → count stays constant. Then assert reset mid-stream → free_count = 63 and preg1 = 1 asynchronously.
